// File: rtl/huff_pkg.sv
// ---------------------------------------------------------------------------
// huff_pkg
// Shared types for the Huffman symbol-frequency stage.
//   state_t     : controller states (IDLE / COUNT / EMIT)
//   tbl_entry_t : one table entry {valid, emitted, sym, count}
// The sym and count fields are sized to the widest supported parameters.
// Instances with narrower symbols or counters use only the low bits.
// The unused upper bits stay zero.
// ---------------------------------------------------------------------------
package huff_pkg;

    // Widest symbol and counter any instance may be built with
    localparam int MAX_SYM_W = 32;
    localparam int MAX_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        EMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 emitted;
        logic [MAX_SYM_W-1:0] sym;
        logic [MAX_CNT_W-1:0] count;
    } tbl_entry_t;

    // All-ones value of a cnt_w-bit counter, i.e. where counting saturates
    function automatic logic [MAX_CNT_W-1:0] sat_value(input int cnt_w);
        logic [MAX_CNT_W-1:0] ones;
        ones = '1;
        return ones >> (MAX_CNT_W - cnt_w);
    endfunction

endpackage

// File: rtl/min_select.sv
// ---------------------------------------------------------------------------
// min_select
// Combinational argmin over DEPTH entries. It is a balanced binary tree
// with $clog2(DEPTH) compare levels and no pipeline stage.
//   elig     in  : per-entry eligibility
//   counts   in  : per-entry counts
//   win_idx  out : index of the eligible entry with the smallest count
//   any_elig out : at least one entry is eligible
//   one_elig out : exactly one entry is eligible
// Ties resolve to the lowest index. The left subtree always covers the
// lower indices, and it wins on equality.
// ---------------------------------------------------------------------------
module min_select #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic [DEPTH-1:0]            elig,
    input  logic [DEPTH-1:0][CNT_W-1:0] counts,
    output logic [$clog2(DEPTH)-1:0]    win_idx,
    output logic                        any_elig,
    output logic                        one_elig
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int LEAVES = 1 << IDX_W;
    localparam int NODES  = 2 * LEAVES - 1;

    // Inputs padded to a power of two. Padding leaves are never eligible.
    logic [LEAVES-1:0]            elig_pad;
    logic [LEAVES-1:0][CNT_W-1:0] cnt_pad;

    assign elig_pad = LEAVES'(elig);
    assign cnt_pad  = (LEAVES * CNT_W)'(counts);

    // Heap layout: node k has children 2k+1 and 2k+2.
    // Leaves occupy LEAVES-1 .. NODES-1.
    logic             node_v [NODES];
    logic [CNT_W-1:0] node_c [NODES];
    logic [IDX_W-1:0] node_i [NODES];

    always_comb begin
        for (int k = 0; k < NODES; k++) begin
            node_v[k] = 1'b0;
            node_c[k] = '0;
            node_i[k] = '0;
        end
        for (int i = 0; i < LEAVES; i++) begin
            node_v[LEAVES-1+i] = elig_pad[i];
            node_c[LEAVES-1+i] = cnt_pad[i];
            node_i[LEAVES-1+i] = IDX_W'(i);
        end
        for (int k = LEAVES - 2; k >= 0; k--) begin
            if (node_v[2*k+1] && (!node_v[2*k+2] || node_c[2*k+1] <= node_c[2*k+2])) begin
                node_c[k] = node_c[2*k+1];
                node_i[k] = node_i[2*k+1];
            end else begin
                node_c[k] = node_c[2*k+2];
                node_i[k] = node_i[2*k+2];
            end
            node_v[k] = node_v[2*k+1] | node_v[2*k+2];
        end
    end

    assign win_idx  = node_i[0];
    assign any_elig = node_v[0];
    // Clearing the lowest set bit leaves zero only for a single-bit vector
    assign one_elig = node_v[0] && ((elig & (elig - DEPTH'(1))) == '0);

endmodule

// File: rtl/freq_table_builder.sv
// ---------------------------------------------------------------------------
// freq_table_builder
// Counts occurrences of distinct symbols in a CAM-style table of DEPTH
// entries. It then emits the entries in ascending count order; ties go to
// the entry seen first.
//   clk, reset            : clock, asynchronous active-high reset
//   ctrl_start, ctrl_done : enter COUNT (clearing the table) / enter EMIT
//   in_valid/in_ready/in_sym                 : symbol input stream
//   out_valid/out_ready/out_sym/out_count/out_last : entry output stream
//   n_entries : distinct symbols stored
//   overflow  : sticky; a new symbol was dropped on a full table
//   busy      : controller is not IDLE
// ---------------------------------------------------------------------------
module freq_table_builder
    import huff_pkg::*;
#(
    parameter int SYM_W = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ctrl_start,
    input  logic                     ctrl_done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SYM_W-1:0]         in_sym,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SYM_W-1:0]         out_sym,
    output logic [CNT_W-1:0]         out_count,
    output logic                     out_last,
    output logic [$clog2(DEPTH+1)-1:0] n_entries,
    output logic                     overflow,
    output logic                     busy
);

    localparam int NW    = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_value(CNT_W));

    state_t        state_q, state_d;
    tbl_entry_t    tbl_q [DEPTH];
    tbl_entry_t    tbl_d [DEPTH];
    logic [NW-1:0] n_entries_q, n_entries_d;
    logic          overflow_q, overflow_d;
    logic          in_ready_q, in_ready_d;

    logic                        hit_any;
    logic [IDX_W-1:0]            hit_idx;
    logic [DEPTH-1:0]            elig;
    logic [DEPTH-1:0][CNT_W-1:0] cnt_vec;
    logic [IDX_W-1:0]            win_idx;
    logic                        any_elig;
    logic                        one_elig;
    tbl_entry_t                  sel_entry;

    // CAM lookup: the incoming symbol is compared with every valid entry at
    // once. Symbols are unique in the table, so at most one entry hits.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl_q[i].valid && tbl_q[i].sym[SYM_W-1:0] == in_sym) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig[i]    = tbl_q[i].valid && !tbl_q[i].emitted;
            cnt_vec[i] = tbl_q[i].count[CNT_W-1:0];
        end
    end

    min_select #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_min_select (
        .elig     (elig),
        .counts   (cnt_vec),
        .win_idx  (win_idx),
        .any_elig (any_elig),
        .one_elig (one_elig)
    );

    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (IDX_W'(i) == win_idx) begin
                sel_entry = tbl_q[i];
            end
        end
    end

    // Outputs are gated by out_valid. Reset therefore drives them to zero
    // immediately, through the asynchronously cleared state.
    assign out_valid = (state_q == EMIT) && any_elig;
    assign out_sym   = out_valid ? sel_entry.sym[SYM_W-1:0]   : '0;
    assign out_count = out_valid ? sel_entry.count[CNT_W-1:0] : '0;
    assign out_last  = out_valid && one_elig;
    assign in_ready  = in_ready_q;
    assign n_entries = n_entries_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != IDLE);

    // Next-state logic. In COUNT, ctrl_start takes precedence over
    // ctrl_done. A restart discards any symbol accepted in that cycle.
    always_comb begin
        state_d     = state_q;
        n_entries_d = n_entries_q;
        overflow_d  = overflow_q;
        for (int i = 0; i < DEPTH; i++) begin
            tbl_d[i] = tbl_q[i];
        end

        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        tbl_d[i] = '0;
                    end
                    n_entries_d = '0;
                    overflow_d  = 1'b0;
                    state_d     = COUNT;
                end
            end

            COUNT: begin
                if (ctrl_start) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        tbl_d[i] = '0;
                    end
                    n_entries_d = '0;
                    overflow_d  = 1'b0;
                end else begin
                    if (in_valid) begin
                        if (hit_any) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                if (IDX_W'(i) == hit_idx && tbl_q[i].count[CNT_W-1:0] != CNT_MAX) begin
                                    tbl_d[i].count[CNT_W-1:0] = tbl_q[i].count[CNT_W-1:0] + CNT_W'(1);
                                end
                            end
                        end else if (n_entries_q < NW'(DEPTH)) begin
                            // Entries fill densely, so the next free slot is index n_entries
                            for (int i = 0; i < DEPTH; i++) begin
                                if (NW'(i) == n_entries_q) begin
                                    tbl_d[i]                  = '0;
                                    tbl_d[i].valid            = 1'b1;
                                    tbl_d[i].sym[SYM_W-1:0]   = in_sym;
                                    tbl_d[i].count[CNT_W-1:0] = CNT_W'(1);
                                end
                            end
                            n_entries_d = n_entries_q + NW'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (ctrl_done) begin
                        state_d = (n_entries_d == '0) ? IDLE : EMIT;
                    end
                end
            end

            EMIT: begin
                if (out_valid && out_ready) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (IDX_W'(i) == win_idx) begin
                            tbl_d[i].emitted = 1'b1;
                        end
                    end
                    if (one_elig) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == COUNT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_entries_q <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            n_entries_q <= n_entries_d;
            overflow_q  <= overflow_d;
            in_ready_q  <= in_ready_d;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

endmodule
